// File: rtl/snake_dir_ctrl_if.sv
// Button, step and command bundle for the snake direction controller.
// master drives buttons/step; slave returns go, pulses and queue level.
interface snake_dir_ctrl_if #(
  parameter int QUEUE_DEPTH = 2,
  parameter int QW = $clog2(QUEUE_DEPTH + 1)
);
  logic          up;
  logic          down;
  logic          left;
  logic          right;
  logic          center;
  logic          step;
  logic [4:0]    go;
  logic          restart;
  logic          drop;
  logic [QW-1:0] q_level;

  modport master (
    output up, down, left, right, center, step,
    input  go, restart, drop, q_level
  );

  modport slave (
    input  up, down, left, right, center, step,
    output go, restart, drop, q_level
  );
endinterface

// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: sync, debounce, press edges, direction queue.
// Define SNAKE_DIR_REVERSAL_LOCK_EN to discard 180-degree reversals.
module snake_dir_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int QUEUE_DEPTH     = 2
) (
  input logic             clk,
  input logic             reset,
  snake_dir_ctrl_if.slave bus
);
  localparam int QW = $clog2(QUEUE_DEPTH + 1);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [4:0] GO_RST = 5'b10000;

  logic [4:0]    raw;
  logic [4:0]    sync_q [SYNC_STAGES];
  logic [4:0]    sync_d [SYNC_STAGES];
  logic [4:0]    deb_q, deb_d;
  logic [4:0]    evt_q, evt_d;
  logic [CW-1:0] cnt_q [5];
  logic [CW-1:0] cnt_d [5];
  logic [4:0]    mem_q [QUEUE_DEPTH];
  logic [4:0]    mem_d [QUEUE_DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [QW-1:0] lvl_q, lvl_d;
  logic [4:0]    go_q, go_d;
  logic          restart_q, restart_d;
  logic          drop_q, drop_d;

  logic [3:0]    dirs;
  logic [4:0]    cand, last;
  logic [PW-1:0] tail_idx;
  logic          multi, full, pop, push, rev;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign raw = {bus.center, bus.right, bus.left, bus.down, bus.up};

  always_comb begin
    sync_d[0] = raw;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing cycles.
  always_comb begin
    deb_d = deb_q;
    for (int b = 0; b < 5; b++) begin
      cnt_d[b] = '0;
      if (sync_q[SYNC_STAGES-1][b] != deb_q[b]) begin
        if (cnt_q[b] == CW'(DEBOUNCE_CYCLES - 1)) deb_d[b] = ~deb_q[b];
        else cnt_d[b] = cnt_q[b] + 1'b1;
      end
    end
    evt_d = deb_d & ~deb_q;
  end

  always_comb begin
    dirs = evt_q[3:0];
    cand = '0;
    if (dirs[0])      cand = 5'b00001;
    else if (dirs[1]) cand = 5'b00010;
    else if (dirs[2]) cand = 5'b00100;
    else if (dirs[3]) cand = 5'b01000;
    multi    = (dirs & (dirs - 4'd1)) != 4'd0;
    tail_idx = (wr_q == '0) ? PW'(QUEUE_DEPTH - 1) : wr_q - 1'b1;
    last     = (lvl_q != '0) ? mem_q[tail_idx] : go_q;
    full     = lvl_q == QW'(QUEUE_DEPTH);
    pop      = bus.step && (lvl_q != '0);
`ifdef SNAKE_DIR_REVERSAL_LOCK_EN
    rev = cand == {1'b0, last[2], last[3], last[0], last[1]};
`else
    rev = 1'b0;
`endif
    go_d      = go_q;
    restart_d = 1'b0;
    drop_d    = 1'b0;
    mem_d     = mem_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    lvl_d     = lvl_q;
    push      = 1'b0;
    if (evt_q[4]) begin
      go_d      = GO_RST;
      restart_d = 1'b1;
      drop_d    = |dirs;
      rd_d      = '0;
      wr_d      = '0;
      lvl_d     = '0;
    end else begin
      if (pop) begin
        go_d = mem_q[rd_q];
        rd_d = nxt(rd_q);
      end
      if (dirs != 4'd0) begin
        if (cand != last) begin
          if (rev || (full && !pop)) drop_d = 1'b1;
          else push = 1'b1;
        end
        if (multi) drop_d = 1'b1;
      end
      if (push) begin
        mem_d[wr_q] = cand;
        wr_d        = nxt(wr_q);
      end
      case ({push, pop})
        2'b10:   lvl_d = lvl_q + 1'b1;
        2'b01:   lvl_d = lvl_q - 1'b1;
        default: lvl_d = lvl_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      for (int b = 0; b < 5; b++) cnt_q[b] <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= '0;
      deb_q     <= '0;
      evt_q     <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      lvl_q     <= '0;
      go_q      <= '0;
      restart_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      mem_q     <= mem_d;
      deb_q     <= deb_d;
      evt_q     <= evt_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      lvl_q     <= lvl_d;
      go_q      <= go_d;
      restart_q <= restart_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.go      = go_q;
  assign bus.restart = restart_q;
  assign bus.drop    = drop_q;
  assign bus.q_level = lvl_q;
endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
- Parametrised next-generation direction controller for the snake game.
- Sits between the five raw push-buttons (up, down, left, right, center) and the game engine; output go is consumed on each game step.
- Adds synchronisation and debounce, press-edge detection, and a direction queue drained one entry per game step, so quick presses between steps are not lost.
- Optionally rejects 180-degree reversals.

Parameters:
SYNC_STAGES, 2, flops in each button synchroniser chain (>=2)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a button level change (>=1); 10 ms at 100 MHz
QUEUE_DEPTH, 2, direction queue entries (>=1)
QW, $clog2(QUEUE_DEPTH+1), width of q_level (derived; not overridden)

Ports:
clk  input  1  system clock, 100 MHz
reset  input  1  asynchronous, active-high reset
up  input  1  raw button, asynchronous
down  input  1  raw button, asynchronous
left  input  1  raw button, asynchronous
right  input  1  raw button, asynchronous
center  input  1  raw button, asynchronous; restart request
step  input  1  one-cycle game-step strobe from the game engine
go  output  5  registered one-hot command: 00001 up, 00010 down, 00100 left, 01000 right, 10000 restart, 00000 idle
restart  output  1  one-cycle pulse on an accepted center press
drop  output  1  one-cycle pulse when a direction press is discarded
q_level  output  QW  number of queued directions

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-high.
- Reset values: go=00000, restart=0, drop=0, q_level=0. Synchronisers, debounced levels and debounce counters all clear to 0.
- Reset mid-operation discards queue contents and any partial debounce count.
- Synchroniser: SYNC_STAGES flops per button.
- Debounce, per button:
  - Counter of width $clog2(DEBOUNCE_CYCLES+1).
  - Counter clears whenever the synchronised input equals the debounced level.
  - Otherwise it increments; on reaching DEBOUNCE_CYCLES the debounced level toggles and the counter clears.
- Press event: rising edge of a debounced level, exactly one cycle. Releases generate nothing. Holding a button gives one event only.
- Same-cycle events:
  - center beats all directions.
  - Among directions, priority is up > down > left > right; lower-priority simultaneous presses are discarded and drop pulses.
- Center event: queue flushed, go <= 10000, restart=1 for one cycle. Overrides a simultaneous step.
- Direction candidate is compared with "last":
  - last = queue tail if q_level>0;
  - otherwise last = go.
- Candidate handling:
  - Equal to last: silently ignored; no drop.
  - Queue full and no simultaneous pop: discarded, drop=1.
  - Otherwise: pushed.
- Step:
  - If q_level>0, the head is popped and go <= head on the same edge.
  - If q_level==0, go holds (continues previous direction, or stays 10000/00000).
- Simultaneous push and pop:
  - Both occur; q_level unchanged.
  - When full, the pop frees a slot so the push is accepted.
  - When empty, the candidate is queued, not bypassed; go changes on the next step.
- Latency: release-to-press-to-queue = SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
- Queue storage: circular buffer, read/write pointers wrap modulo QUEUE_DEPTH.
- q_level range: never exceeds QUEUE_DEPTH and never underflows.

Optional Feature:
- Macro: SNAKE_DIR_REVERSAL_LOCK_EN.
- Defined: a candidate opposite to last (up/down, left/right) is discarded and drop=1. No check is made when last is 00000 or 10000.
- Undefined: opposite directions are treated like any other direction and queued.

Test Plan (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2, QUEUE_DEPTH=2):
1. up glitch high 3 cycles -> q_level stays 0. up held 8 cycles -> q_level=1 exactly 7 cycles after assertion. Pulse step -> go=00001, q_level=0.
2. go=00001, press down. Lock on: drop pulses once, q_level=0, go=00001 after step. Lock off: go=00010 after step.
3. go=00001, press left, release, press down before any step -> q_level=2. step -> go=00100; step -> go=00010; third step -> go holds 00010.
4. Queue full (left, down), press right -> drop=1, q_level=2. Repeat with step asserted in the push cycle -> no drop, q_level=2.
5. q_level=2, press center with step in the same cycle -> go=10000, restart high one cycle, q_level=0. Next up press plus step -> go=00001.
6. Assert reset mid-debounce with q_level=1 -> go=00000, q_level=0, drop=0, restart=0 immediately. No press event after release of reset while the button remains held stable at its pre-reset level.
